// File: rtl/prim_ram_1p_adapter_if.sv
// Request/response stream bundle between an upstream client and prim_ram_1p_adapter.
// The master modport is the client side and the slave modport is the adapter side.
// Signal suffixes (_i/_o) are written from the adapter's point of view.
interface prim_ram_1p_adapter_if #(
    parameter int Width = 32,
    parameter int Aw    = 7
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_write_i;
    logic [Aw-1:0]    req_addr_i;
    logic [Width-1:0] req_wdata_i;
    logic [Width-1:0] req_wmask_i;

    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [Width-1:0] rsp_rdata_o;
    logic             rsp_write_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_write_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_write_o
    );
endinterface

// File: rtl/prim_ram_1p_adapter.sv
// Front end for a generic single-port RAM with a fixed 1-cycle read latency.
// Requests are accepted only when the response FIFO has room for the result, so
// read data is never dropped under response backpressure.
// Optional feature: define PRIM_RAM_1P_ADAPTER_WACK_EN to make every write consume a
// credit and return an in-order acknowledge (rsp_write_o=1, rsp_rdata_o=0).
module prim_ram_1p_adapter #(
    parameter int Width    = 32,
    parameter int Depth    = 128,
    parameter int RspDepth = 2,
    localparam int Aw      = $clog2(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    prim_ram_1p_adapter_if.slave   bus,
    output logic                   ram_req_o,
    output logic                   ram_write_o,
    output logic [Aw-1:0]          ram_addr_o,
    output logic [Width-1:0]       ram_wdata_o,
    output logic [Width-1:0]       ram_wmask_o,
    input  logic [Width-1:0]       ram_rdata_i
);

`ifdef PRIM_RAM_1P_ADAPTER_WACK_EN
    localparam bit WackEn = 1'b1;
`else
    localparam bit WackEn = 1'b0;
`endif

    localparam int PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW  = $clog2(RspDepth + 1);
    localparam int CntW1 = CntW + 1;
    localparam logic [CntW-1:0] CountFull = CntW'(RspDepth);
    localparam logic [CntW:0]   DepthExt  = CntW1'(RspDepth);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(RspDepth - 1);

    // State
    logic                r_inflight;
    logic [CntW-1:0]     r_count;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [PtrW-1:0]     r_wr_ptr;
    logic [Width-1:0]    r_fifo_data [RspDepth];
`ifdef PRIM_RAM_1P_ADAPTER_WACK_EN
    logic                r_inflight_write;
    logic                r_fifo_write [RspDepth];
`endif

    // Combinational
    logic                w_pop;
    logic                w_push;
    logic [Width-1:0]    w_push_data;
    logic [CntW:0]       w_used;
    logic [CntW:0]       w_avail;
    logic                w_has_credit;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_inflight_next;
    logic                w_rsp_valid;
    logic [CntW-1:0]     w_count_next;
    logic [PtrW-1:0]     w_rd_ptr_next;
    logic [PtrW-1:0]     w_wr_ptr_next;

    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready_i;

    // The RAM result arrives exactly one cycle after the accept, so the in-flight
    // flag doubles as the FIFO push strobe.
    assign w_push = r_inflight;

`ifdef PRIM_RAM_1P_ADAPTER_WACK_EN
    assign w_push_data = r_inflight_write ? '0 : ram_rdata_i;
`else
    assign w_push_data = ram_rdata_i;
`endif

    // Credit is RspDepth - count - inflight + pop; only its sign matters, so compare
    // the two sides instead of forming a signed difference.
    assign w_used       = {1'b0, r_count} + {{CntW{1'b0}}, r_inflight};
    assign w_avail      = DepthExt + {{CntW{1'b0}}, w_pop};
    assign w_has_credit = (w_avail > w_used);

    // Ready never looks at req_valid_i; it may look at req_write_i and rsp_ready_i.
    assign w_req_ready     = !rst_i & (w_has_credit | (bus.req_write_i & !WackEn));
    assign w_accept        = bus.req_valid_i & w_req_ready;
    assign w_inflight_next = w_accept & (!bus.req_write_i | WackEn);

    assign bus.req_ready_o = w_req_ready;
    assign ram_req_o       = w_accept;
    assign ram_write_o     = bus.req_write_i;
    assign ram_addr_o      = bus.req_addr_i;
    assign ram_wdata_o     = bus.req_wdata_i;
    assign ram_wmask_o     = bus.req_wmask_i;

    // Head of the FIFO drives the response; forced to zero when empty so the
    // outputs are clean after reset.
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_rdata_o = w_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
`ifdef PRIM_RAM_1P_ADAPTER_WACK_EN
    assign bus.rsp_write_o = w_rsp_valid & r_fifo_write[r_rd_ptr];
`else
    assign bus.rsp_write_o = 1'b0;
`endif

    // Next-state for occupancy and the wrapping circular pointers.
    always_comb begin
        w_count_next  = r_count;
        w_rd_ptr_next = r_rd_ptr;
        w_wr_ptr_next = r_wr_ptr;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
        if (w_push) begin
            w_wr_ptr_next = (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_next = (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Control registers; reset drops any in-flight read and empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            r_count    <= w_count_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_ptr   <= w_wr_ptr_next;
        end
    end

    // FIFO data storage, written at the write pointer on push; no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
        end
    end

`ifdef PRIM_RAM_1P_ADAPTER_WACK_EN
    // Remember whether the in-flight slot is a write acknowledge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight_write <= 1'b0;
        end else begin
            r_inflight_write <= w_accept & bus.req_write_i;
        end
    end

    // Response-kind storage alongside the data entries.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr] <= r_inflight_write;
        end
    end
`endif

    // Sanity checks: legal FIFO depth, and credit accounting must make overflow impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (RspDepth >= 2)
                else $error("prim_ram_1p_adapter: RspDepth must be at least 2");
            assert (!(w_push && !w_pop && (r_count == CountFull)))
                else $error("prim_ram_1p_adapter: push into full response FIFO");
        end
    end

endmodule

// File: tb/tb_prim_ram_1p_adapter.sv
// Self-checking bench for prim_ram_1p_adapter with a behavioural 1-cycle-latency RAM.
// Honors PRIM_RAM_1P_ADAPTER_WACK_EN for the expected write acknowledges.
module tb_prim_ram_1p_adapter;

`ifdef PRIM_RAM_1P_ADAPTER_WACK_EN
    localparam bit WackEn = 1'b1;
`else
    localparam bit WackEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_req;
    logic        ram_write;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_wmask;
    logic [31:0] ram_rdata = '0;

    logic        tb_init = 1'b0;
    logic        tb_load = 1'b0;
    logic [6:0]  tb_load_addr = '0;
    logic [31:0] tb_load_data = '0;
    logic [31:0] mem [128];

    prim_ram_1p_adapter_if #(.Width(32), .Aw(7)) bus ();

    prim_ram_1p_adapter #(.Width(32), .Depth(128), .RspDepth(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .ram_req_o   (ram_req),
        .ram_write_o (ram_write),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: masked write, registered read.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'(i * 17);
        end else if (tb_load) begin
            mem[tb_load_addr] <= tb_load_data;
        end else if (ram_req) begin
            if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            else           ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        w;
        logic [31:0] d;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [31:0] exp;
    } vec_t;

    exp_t        expq[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_seen = 0;
    logic        s_ready, s_ram_req, s_rsp_valid, s_rsp_write;
    logic [31:0] s_rsp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, score any consumed response.
    task automatic step(input logic r, input logic v, input logic w, input logic [6:0] a,
                        input logic [31:0] d, input logic [31:0] m, input logic rr,
                        input logic [31:0] exp_d, input bit chk_lat, output logic acc);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.req_valid_i  = v;
        bus.req_write_i  = w;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = d;
        bus.req_wmask_i  = m;
        bus.rsp_ready_i  = rr;
        #1;
        s_ready     = bus.req_ready_o;
        s_ram_req   = ram_req;
        s_rsp_valid = bus.rsp_valid_o;
        s_rsp_rdata = bus.rsp_rdata_o;
        s_rsp_write = bus.rsp_write_o;
        acc = v & s_ready;
        if (s_rsp_valid && rr && !r) begin
            rsp_seen++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h write=%b, required no response (cycle %0d)",
                         s_rsp_rdata, s_rsp_write, cyc);
            end else begin
                e = expq.pop_front();
                chk("rsp_rdata", s_rsp_rdata, e.d);
                chk("rsp_write", 32'(s_rsp_write), 32'(e.w));
                if (e.chk_lat) chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'd2);
            end
        end
        if (acc && (!w || WackEn)) begin
            e.w = w;
            e.d = w ? 32'h0 : exp_d;
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat;
            expq.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input logic rr);
        logic acc;
        step(1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, rr, 32'h0, 1'b0, acc);
    endtask

    // Present one request until accepted, bounded.
    task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d,
                         input logic [31:0] m, input logic [31:0] exp_d, input bit chk_lat);
        logic acc;
        bit   done;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            step(1'b0, 1'b1, w, a, d, m, 1'b1, exp_d, chk_lat, acc);
            done = acc;
        end
        chk("issue_accepted", 32'(done), 32'd1);
    endtask

    // Consume all outstanding responses, bounded, then watch for strays.
    task automatic drain();
        for (int k = 0; k < 20 && expq.size() != 0; k++) idle(1'b1);
        chk("drain_empty", 32'(expq.size()), 32'd0);
        idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        logic        acc;
        logic [31:0] prev_rdata;
        logic        prev_hold;
        int          p;
        int          seen0;

        // Directed single-transaction vectors (mem[5] preloaded with 0x12345678).
        vecs[0]  = '{1'b1, 7'd5,   32'hDEADBEEF, 32'hFFFF0000, 32'h0};
        vecs[1]  = '{1'b0, 7'd5,   32'h0,        32'h0,        32'hDEAD5678};
        vecs[2]  = '{1'b1, 7'd10,  32'hA5A5A5A5, 32'h000000FF, 32'h0};
        vecs[3]  = '{1'b0, 7'd10,  32'h0,        32'h0,        32'h000000A5};
        vecs[4]  = '{1'b1, 7'd3,   32'h01234567, 32'hFFFFFFFF, 32'h0};
        vecs[5]  = '{1'b0, 7'd3,   32'h0,        32'h0,        32'h01234567};
        vecs[6]  = '{1'b1, 7'd3,   32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0};
        vecs[7]  = '{1'b0, 7'd3,   32'h0,        32'h0,        32'h0F2F4F6F};
        vecs[8]  = '{1'b0, 7'd127, 32'h0,        32'h0,        32'h0000086F};
        vecs[9]  = '{1'b1, 7'd127, 32'hCAFEF00D, 32'h00000000, 32'h0};
        vecs[10] = '{1'b0, 7'd127, 32'h0,        32'h0,        32'h0000086F};
        vecs[11] = '{1'b0, 7'd0,   32'h0,        32'h0,        32'h0};

        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_wmask_i = '0;
        bus.rsp_ready_i = 1'b0;

        // Preload mem[i] = i*0x11 while in reset.
        @(negedge clk); tb_init = 1'b1;
        @(negedge clk); tb_init = 1'b0;

        // Reset state: outputs quiet, request blocked even with valid high.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 7'd1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
            chk("reset_req_ready", 32'(s_ready), 32'd0);
            chk("reset_ram_req", 32'(s_ram_req), 32'd0);
            chk("reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
            chk("reset_rsp_rdata", s_rsp_rdata, 32'd0);
            chk("reset_rsp_write", 32'(s_rsp_write), 32'd0);
        end
        expq.delete();

        // Back-to-back reads 0..7: ready stays high, one response per cycle at latency 2.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 7'(i), 32'h0, 32'h0, 1'b1, 32'(i * 17), 1'b1, acc);
            chk("b2b_req_ready", 32'(s_ready), 32'd1);
            chk("b2b_ram_req", 32'(s_ram_req), 32'd1);
        end
        drain();

        // Backpressure: only RspDepth reads accepted, head held stable, then release.
        p = 0;
        prev_hold = 1'b0;
        prev_rdata = '0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 7'(p), 32'h0, 32'h0, 1'b0, 32'(p * 17), 1'b0, acc);
            if (acc) p++;
            if (prev_hold) chk("bp_head_stable", s_rsp_rdata, prev_rdata);
            prev_hold  = s_rsp_valid;
            prev_rdata = s_rsp_rdata;
        end
        chk("bp_accepted", 32'(p), 32'd2);
        chk("bp_req_ready_low", 32'(s_ready), 32'd0);
        chk("bp_head_data", s_rsp_rdata, 32'h0);
        for (int k = 0; k < 30 && !(p == 8 && expq.size() == 0); k++) begin
            step(1'b0, p < 8, 1'b0, 7'(p), 32'h0, 32'h0, 1'b1, 32'(p * 17), 1'b0, acc);
            if (acc) p++;
        end
        chk("bp_all_accepted", 32'(p), 32'd8);
        chk("bp_all_returned", 32'(expq.size()), 32'd0);

        // Reset with one FIFO entry and one read in flight: nothing comes back.
        step(1'b0, 1'b1, 1'b0, 7'd1, 32'h0, 32'h0, 1'b0, 32'h11, 1'b0, acc);
        chk("rst_setup_acc0", 32'(acc), 32'd1);
        step(1'b0, 1'b1, 1'b0, 7'd2, 32'h0, 32'h0, 1'b0, 32'h22, 1'b0, acc);
        chk("rst_setup_acc1", 32'(acc), 32'd1);
        step(1'b1, 1'b1, 1'b0, 7'd3, 32'h0, 32'h0, 1'b0, 32'h33, 1'b0, acc);
        chk("rst_pulse_req_ready", 32'(s_ready), 32'd0);
        chk("rst_pulse_ram_req", 32'(s_ram_req), 32'd0);
        expq.delete();
        idle(1'b1);
        chk("rst_after_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("rst_after_rsp_rdata", s_rsp_rdata, 32'd0);
        for (int k = 0; k < 5; k++) idle(1'b1);

        // Write addr 5 over a known old value for the masked-merge vectors.
        @(negedge clk); tb_load = 1'b1; tb_load_addr = 7'd5; tb_load_data = 32'h12345678;
        @(negedge clk); tb_load = 1'b0;

        // Table-driven single transactions.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].exp, 1'b1);
            drain();
        end

        // Pointer wrap: tag 6 words, then stream 6 reads under intermittent backpressure.
        for (int i = 0; i < 6; i++)
            issue(1'b1, 7'(40 + i), 32'hC0DE0000 + 32'(i), 32'hFFFFFFFF, 32'h0, 1'b0);
        drain();
        p = 0;
        for (int k = 0; k < 30 && !(p == 6 && expq.size() == 0); k++) begin
            step(1'b0, p < 6, 1'b0, 7'(40 + p), 32'h0, 32'h0, (k >= 3) && (k != 6),
                 32'hC0DE0000 + 32'(p), 1'b0, acc);
            if (acc) p++;
        end
        chk("wrap_all_accepted", 32'(p), 32'd6);
        chk("wrap_all_returned", 32'(expq.size()), 32'd0);

        // Write, read, write: acknowledges only when write responses are enabled.
        seen0 = rsp_seen;
        issue(1'b1, 7'd60, 32'h600D0060, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(1'b0, 7'd60, 32'h0, 32'h0, 32'h600D0060, 1'b0);
        issue(1'b1, 7'd61, 32'h00000061, 32'hFFFFFFFF, 32'h0, 1'b0);
        drain();
        chk("wrw_rsp_count", 32'(rsp_seen - seen0), WackEn ? 32'd3 : 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
